spu_register_file: RTL
======================

Name: spu_register_file

Overview:
- 128-entry x 128-bit SPU unified register file at the RF/FWD stage boundary.
- Sits directly downstream of the execution-unit writeback outputs (rt_wb / rt_addr_wb / reg_write_wb) from the even and odd pipes.
- Sits directly upstream of the execution units, supplying the registered ra/rb/rc operand values.
- Provides two write ports (even and odd pipe), three read ports with write-through bypass, a stall hold and a write-conflict flag.

Parameters:
- NUM_REGS, 128, number of architectural registers.
- DATA_W, 128, register width in bits, big-endian [0:DATA_W-1].
- ADDR_W, 7, register address width, log2(NUM_REGS).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- stall  in  1  hold read outputs; writes still commit.
- ra_addr  in  7  read port A address.
- rb_addr  in  7  read port B address.
- rc_addr  in  7  read port C address.
- ra  out  128  port A data, registered.
- rb  out  128  port B data, registered.
- rc  out  128  port C data, registered.
- rt_wb_even  in  128  even-pipe writeback data.
- rt_addr_wb_even  in  7  even-pipe destination address.
- reg_write_wb_even  in  1  even-pipe write enable.
- rt_wb_odd  in  128  odd-pipe writeback data.
- rt_addr_wb_odd  in  7  odd-pipe destination address.
- reg_write_wb_odd  in  1  odd-pipe write enable.
- wr_conflict  out  1  registered pulse: both pipes wrote the same address this edge.

Behaviour:
- Reset (synchronous):
  - All 128 entries cleared to 0.
  - ra, rb, rc and wr_conflict cleared to 0.
  - Reset overrides stall and any concurrent writes; writes presented in the reset cycle are dropped.
- Write:
  - At posedge with reg_write_wb_even=1, entry[rt_addr_wb_even] <= rt_wb_even; odd port likewise.
  - Address/data are ignored when the matching enable is 0.
- Simultaneous writes to the same address:
  - Odd pipe wins.
  - wr_conflict=1 for exactly one cycle after that edge, else 0.
  - Writes to different addresses both commit.
- Read latency: 1 cycle. Addresses sampled at posedge N; data visible on ra/rb/rc after edge N.
- Bypass (write-through):
  - If a read address equals a write address enabled at the same edge, the output takes the new write data, not the stale array value.
  - Priority per read port: odd write match > even write match > array contents.
- All three read ports are independent. Any port may read any address, including all three reading the same address.
- Register 0 is ordinary storage; it is not hardwired to zero.
- stall=1:
  - ra, rb, rc hold their previous values and addresses are ignored.
  - Writes and wr_conflict still update.
  - After stall deasserts, the next read returns current array contents, including writes made during the stall.
- No internal state machine beyond the array and the output registers. Each output is a pure function of the previous-edge inputs and the array.

Decomposition:
- Shared package spu_pkg:
  - constants NUM_REGS, DATA_W, ADDR_W;
  - typedefs reg_addr_t (logic [0:6]) and quadword_t (logic [0:127]);
  - a wb_bus_t struct {data, addr, wen}, reused by the execution units' writeback outputs.
- One natural sub-module, rf_read_port: a single registered read path with two-level bypass mux and stall hold, instantiated three times.
- Array storage and write/conflict logic stay in the top module.

Test Plan:
- Reset then read: assert reset 1 cycle; read ra_addr=5, rb_addr=127, rc_addr=0 -> ra=rb=rc=0, wr_conflict=0.
- Write/read: even write addr 10 = 128'h0123...CDEF; next cycle ra_addr=10 -> ra=128'h0123...CDEF after one edge.
- Same-edge bypass: at edge N, odd write addr 3 = 128'hAAAA...; ra_addr=rb_addr=3 at edge N -> ra=rb=128'hAAAA... after edge N.
- Conflict: even writes addr 7 = 128'h1111..., odd writes addr 7 = 128'h2222... at the same edge -> wr_conflict=1 for one cycle; subsequent read of addr 7 returns 128'h2222....
- Stall hold: with ra=128'h5555... from addr 20, assert stall for 3 cycles while writing addr 20 = 128'h6666... and switching ra_addr to 21 -> ra stays 128'h5555... for all 3 cycles; after deassert with ra_addr=20 -> ra=128'h6666....
- Reset mid-operation: write addr 40 = 128'hFFFF...; assert reset concurrently with an even write to addr 41 -> after reset, reads of 40 and 41 both return 0.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared SPU definitions: register-file geometry, operand/address types and
// the writeback bus bundle driven by the even and odd execution pipes.
// Vectors are big-endian: bit 0 is the most significant bit.
package spu_pkg;

    localparam int NUM_REGS = 128;
    localparam int DATA_W   = 128;
    localparam int ADDR_W   = 7;

    typedef logic [0:ADDR_W-1] reg_addr_t;
    typedef logic [0:DATA_W-1] quadword_t;

    typedef struct packed {
        quadword_t data;
        reg_addr_t addr;
        logic      wen;
    } wb_bus_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered register-file read path.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   stall              hold rd_data and ignore rd_addr
//   rd_addr            read address sampled at the clock edge
//   rd_array_data      array contents at rd_addr, before this edge's writes
//   wb_even, wb_odd    writebacks committing at this edge, used for bypass
//   rd_data            registered read data
module rf_read_port
    import spu_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      stall,
    input  reg_addr_t rd_addr,
    input  quadword_t rd_array_data,
    input  wb_bus_t   wb_even,
    input  wb_bus_t   wb_odd,
    output quadword_t rd_data
);

    quadword_t rd_data_q;
    quadword_t rd_data_d;

    // Odd pipe is checked first so it wins when both pipes target the
    // address being read, matching the array's write priority.
    always_comb begin
        rd_data_d = rd_array_data;
        if (wb_odd.wen && (wb_odd.addr == rd_addr)) begin
            rd_data_d = wb_odd.data;
        end else if (wb_even.wen && (wb_even.addr == rd_addr)) begin
            rd_data_d = wb_even.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (!stall) begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/spu_register_file.sv
// SPU unified register file: 128 x 128-bit, two write ports (even/odd pipe),
// three registered read ports with write-through bypass.
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   stall                            hold ra/rb/rc; writes still commit
//   ra_addr, rb_addr, rc_addr        read addresses
//   ra, rb, rc                       registered read data (1-cycle latency)
//   rt_wb_even/rt_addr_wb_even/reg_write_wb_even   even-pipe writeback
//   rt_wb_odd/rt_addr_wb_odd/reg_write_wb_odd      odd-pipe writeback
//   wr_conflict                      one-cycle pulse: both pipes wrote the
//                                    same address at the previous edge
module spu_register_file
    import spu_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      stall,
    input  reg_addr_t ra_addr,
    input  reg_addr_t rb_addr,
    input  reg_addr_t rc_addr,
    output quadword_t ra,
    output quadword_t rb,
    output quadword_t rc,
    input  quadword_t rt_wb_even,
    input  reg_addr_t rt_addr_wb_even,
    input  logic      reg_write_wb_even,
    input  quadword_t rt_wb_odd,
    input  reg_addr_t rt_addr_wb_odd,
    input  logic      reg_write_wb_odd,
    output logic      wr_conflict
);

    quadword_t mem_q [NUM_REGS];
    wb_bus_t   wb_even;
    wb_bus_t   wb_odd;
    logic      wr_conflict_q;
    logic      wr_conflict_d;

    assign wb_even = '{data: rt_wb_even, addr: rt_addr_wb_even, wen: reg_write_wb_even};
    assign wb_odd  = '{data: rt_wb_odd,  addr: rt_addr_wb_odd,  wen: reg_write_wb_odd};

    assign wr_conflict_d = wb_even.wen && wb_odd.wen && (wb_even.addr == wb_odd.addr);

    // The odd write is issued after the even one so it takes effect last
    // when both target the same entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
            wr_conflict_q <= 1'b0;
        end else begin
            if (wb_even.wen) begin
                mem_q[wb_even.addr] <= wb_even.data;
            end
            if (wb_odd.wen) begin
                mem_q[wb_odd.addr] <= wb_odd.data;
            end
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign wr_conflict = wr_conflict_q;

    rf_read_port u_port_a (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .rd_addr       (ra_addr),
        .rd_array_data (mem_q[ra_addr]),
        .wb_even       (wb_even),
        .wb_odd        (wb_odd),
        .rd_data       (ra)
    );

    rf_read_port u_port_b (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .rd_addr       (rb_addr),
        .rd_array_data (mem_q[rb_addr]),
        .wb_even       (wb_even),
        .wb_odd        (wb_odd),
        .rd_data       (rb)
    );

    rf_read_port u_port_c (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .rd_addr       (rc_addr),
        .rd_array_data (mem_q[rc_addr]),
        .wb_even       (wb_even),
        .wb_odd        (wb_odd),
        .rd_data       (rc)
    );

endmodule
